pipeline_register_file: RTL and testbench

Parametrised successor to the single-cycle integer register file, for the pipelined core. Provides N combinational read ports, one synchronous write port, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection. After reset it zeroes its storage with a one-entry-per-cycle sweep and holds `o_ready` low until the sweep completes. Sits between decode (reads, reservations) and writeback (writes).

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_read_port.sv | 56 +++++
 rtl/pipeline_register_file.sv | 126 ++++++++++++
 tb/tb_pipeline_register_file.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the pipelined integer register file.
//   rf_state_t : CLEAR (the post-reset zeroing sweep is running) or
//                READY (the write and reserve ports are accepted).
//   rf_addr_w  : register-address width for a given register count. Decode
//                can use it so that its address fields match this block.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  // Address width for n registers. The result is never below 1, so a
  // degenerate count still gives a legal vector width.
  function automatic int rf_addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read lane of the register file.
// It applies three masks in priority order:
//   1. Not ready (sweep still running) or address 0: data 0, busy 0.
//   2. Bypass is enabled and the same-cycle write targets this address:
//      the lane returns the write data, and busy is 0 because the writer
//      is the producer that was pending.
//   3. Otherwise the lane returns the stored word and its busy bit.
// Ports:
//   ready         : register file has left CLEAR
//   addr          : register address for this lane
//   mem_data      : stored word at addr, from the top-level array
//   mem_busy      : scoreboard bit at addr
//   write_enable  : writeback strobe
//   write_address : writeback register
//   write_data    : writeback value
//   data / busy   : lane outputs
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              mem_busy,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [XLEN-1:0]   write_data,
  output logic [XLEN-1:0]   data,
  output logic              busy
);

  logic addr_zero;
  logic bypass_hit;

  assign addr_zero = (addr == '0);

  // The write ports are ignored during CLEAR, so forwarding is also
  // qualified by ready. A write to entry 0 is never forwarded because
  // the zero-address mask takes priority below.
  assign bypass_hit = (BYPASS != 0) && ready && write_enable &&
                      (write_address == addr);

  always_comb begin
    data = mem_data;
    busy = mem_busy;
    if (!ready || addr_zero) begin
      data = '0;
      busy = 1'b0;
    end else if (bypass_hit) begin
      data = write_data;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_register_file.sv
// Pipelined-core integer register file.
// It has NUM_READ_PORTS combinational read ports, one synchronous write
// port, optional write-to-read bypass and a per-register busy scoreboard.
// After reset, a sweep zeroes entries 1..NUM_REGS-1, one entry per cycle.
// While the sweep runs, o_ready stays low and the write and reserve ports
// are ignored.
// Ports:
//   i_clk, i_rst      : clock and synchronous active-high reset
//   i_readAddress     : packed per-port read addresses
//   o_readData        : per-port read data
//   o_readBusy        : per-port "addressed register has a pending producer"
//   i_writeEnable/Address/Data     : writeback port
//   i_reserveEnable/Address        : decode reservation (marks busy)
//   o_ready           : sweep finished; the write and reserve ports are live
module pipeline_register_file
  import rf_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int NUM_REGS       = 32,
  parameter  int NUM_READ_PORTS = 2,
  parameter  int BYPASS         = 1,
  localparam int ADDR_W         = rf_addr_w(NUM_REGS)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_READ_PORTS-1:0][ADDR_W-1:0] i_readAddress,
  output logic [NUM_READ_PORTS-1:0][XLEN-1:0]   o_readData,
  output logic [NUM_READ_PORTS-1:0]             o_readBusy,
  input  logic                                i_writeEnable,
  input  logic [ADDR_W-1:0]                   i_writeAddress,
  input  logic [XLEN-1:0]                     i_writeData,
  input  logic                                i_reserveEnable,
  input  logic [ADDR_W-1:0]                   i_reserveAddress,
  output logic                                o_ready
);

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(NUM_REGS - 1);

  rf_state_t           state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic [XLEN-1:0]     mem [NUM_REGS];

  logic                ready;
  logic                write_hit;
  logic                reserve_hit;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [XLEN-1:0]     mem_wdata;

  assign ready       = (state_reg == READY);
  assign o_ready     = ready;
  assign write_hit   = ready && i_writeEnable   && (i_writeAddress   != '0);
  assign reserve_hit = ready && i_reserveEnable && (i_reserveAddress != '0);

  // Next-state logic for the FSM, the sweep pointer and the scoreboard.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    busy_next  = busy_reg;
    if (state_reg == CLEAR) begin
      ptr_next = ptr_reg + 1'b1;
      if (ptr_reg == LAST_ENTRY) begin
        state_next = READY;
      end
    end else begin
      // The clear is applied before the set. When the write and the
      // reservation hit the same register, the reservation is the newer
      // producer, so the busy bit ends up set.
      if (write_hit) begin
        busy_next[i_writeAddress] = 1'b0;
      end
      if (reserve_hit) begin
        busy_next[i_reserveAddress] = 1'b1;
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= CLEAR;
      ptr_reg   <= ADDR_W'(1);
      busy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= busy_next;
    end
  end

  // The array has a single write port. During CLEAR the sweep owns it, and
  // during READY writeback owns it. Entry 0 is never written: the sweep
  // starts at 1, and write_hit excludes address 0.
  assign mem_we    = !i_rst && ((state_reg == CLEAR) || write_hit);
  assign mem_waddr = (state_reg == CLEAR) ? ptr_reg : i_writeAddress;
  assign mem_wdata = (state_reg == CLEAR) ? '0 : i_writeData;

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read_port
      rf_read_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
      ) u_read_port (
        .ready         (ready),
        .addr          (i_readAddress[gi]),
        .mem_data      (mem[i_readAddress[gi]]),
        .mem_busy      (busy_reg[i_readAddress[gi]]),
        .write_enable  (i_writeEnable),
        .write_address (i_writeAddress),
        .write_data    (i_writeData),
        .data          (o_readData[gi]),
        .busy          (o_readBusy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_register_file.sv
// Directed bench for pipeline_register_file. It builds three instances:
//   dut_a : defaults with BYPASS=0
//   dut_b : defaults with BYPASS=1 (shares dut_a's stimulus)
//   dut_c : NUM_REGS=16, NUM_READ_PORTS=3, BYPASS=1
module tb_pipeline_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for dut_a and dut_b.
  logic            rst, we, re;
  logic [4:0]      wa, rsa;
  logic [31:0]     wd;
  logic [1:0][4:0] ra;
  logic [1:0][31:0] da, db;
  logic [1:0]      ba, bb;
  logic            rdy_a, rdy_b;

  // Stimulus for dut_c.
  logic             rst_c, we_c, re_c;
  logic [3:0]       wa_c, rsa_c;
  logic [31:0]      wd_c;
  logic [2:0][3:0]  ra_c;
  logic [2:0][31:0] dc;
  logic [2:0]       bc;
  logic             rdy_c;

  int checks   = 0;
  int failures = 0;

  pipeline_register_file #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .BYPASS(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_readAddress(ra), .o_readData(da), .o_readBusy(ba),
    .i_writeEnable(we), .i_writeAddress(wa), .i_writeData(wd),
    .i_reserveEnable(re), .i_reserveAddress(rsa), .o_ready(rdy_a));

  pipeline_register_file #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .BYPASS(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_readAddress(ra), .o_readData(db), .o_readBusy(bb),
    .i_writeEnable(we), .i_writeAddress(wa), .i_writeData(wd),
    .i_reserveEnable(re), .i_reserveAddress(rsa), .o_ready(rdy_b));

  pipeline_register_file #(.XLEN(32), .NUM_REGS(16), .NUM_READ_PORTS(3), .BYPASS(1)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_readAddress(ra_c), .o_readData(dc), .o_readBusy(bc),
    .i_writeEnable(we_c), .i_writeAddress(wa_c), .i_writeData(wd_c),
    .i_reserveEnable(re_c), .i_reserveAddress(rsa_c), .o_ready(rdy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; rsa = '0; wd = '0; ra = '0;
    rst_c = 1'b1; we_c = 1'b0; re_c = 1'b0; wa_c = '0; rsa_c = '0; wd_c = '0; ra_c = '0;

    // ---------------- reset and sweep (32 regs) ----------------
    @(posedge clk); #1; rst = 1'b0; ra[0] = 5'd1; ra[1] = 5'd2; #1;
    $display("step reset: dut_a/dut_b reset edge taken");
    chk("rst_ready_a", rdy_a, 0);
    chk("rst_ready_b", rdy_b, 0);
    chk("rst_data_a0", da[0], 0);
    chk("rst_data_b1", db[1], 0);
    chk("rst_busy_a", ba, 0);
    chk("rst_busy_b", bb, 0);
    for (int i = 0; i < 31; i++) begin
      chk("sweep_ready_a", rdy_a, 0);
      chk("sweep_ready_b", rdy_b, 0);
      if (i == 10) begin
        we = 1'b1; wa = 5'd3; wd = 32'h55; re = 1'b1; rsa = 5'd4;
        ra[0] = 5'd3; ra[1] = 5'd4; #1;
        $display("step gate: write r3=0x55 reserve r4 during sweep");
        chk("gate_bypass_data_b", db[0], 0);
        chk("gate_busy_b", bb[1], 0);
      end
      @(posedge clk); #1; we = 1'b0; re = 1'b0; #1;
    end
    chk("sweep_done_a", rdy_a, 1);
    chk("sweep_done_b", rdy_b, 1);
    ra[0] = 5'd3; ra[1] = 5'd4; #1;
    chk("gate_r3_a", da[0], 0);
    chk("gate_r3_b", db[0], 0);
    chk("gate_r4_busy_a", ba[1], 0);
    chk("gate_r4_busy_b", bb[1], 0);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a); #1;
      chk("clear_data_a0", da[0], 0);
      chk("clear_data_a1", da[1], 0);
      chk("clear_data_b0", db[0], 0);
      chk("clear_data_b1", db[1], 0);
      chk("clear_busy_a", ba, 0);
      chk("clear_busy_b", bb, 0);
    end
    $display("step sweep: all entries read back after sweep");

    // ---------------- write / read r5 ----------------
    @(posedge clk); #1;
    ra[0] = 5'd5; ra[1] = 5'd0; we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; #1;
    $display("step write: r5=0xDEADBEEF");
    chk("w5_same_cycle_a", da[0], 32'h0);
    chk("w5_same_cycle_b", db[0], 32'hDEADBEEF);
    @(posedge clk); #1; we = 1'b0; #1;
    chk("w5_next_cycle_a", da[0], 32'hDEADBEEF);
    chk("w5_next_cycle_b", db[0], 32'hDEADBEEF);

    // ---------------- entry 0 ----------------
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; re = 1'b1; rsa = 5'd0;
    ra[0] = 5'd0; ra[1] = 5'd0; #1;
    $display("step r0: write 0x12345678 and reserve r0");
    chk("r0_data_a0", da[0], 0);
    chk("r0_data_b0", db[0], 0);
    chk("r0_data_b1", db[1], 0);
    chk("r0_busy_b", bb, 0);
    @(posedge clk); #1; we = 1'b0; re = 1'b0; #1;
    chk("r0_after_data_a", da[1], 0);
    chk("r0_after_data_b", db[0], 0);
    chk("r0_after_busy_a", ba, 0);
    chk("r0_after_busy_b", bb, 0);

    // ---------------- scoreboard r7 ----------------
    re = 1'b1; rsa = 5'd7; ra[0] = 5'd7; #1;
    $display("step reserve: r7");
    chk("r7_busy_before_a", ba[0], 0);
    @(posedge clk); #1; re = 1'b0; #1;
    chk("r7_busy_a", ba[0], 1);
    chk("r7_busy_b", bb[0], 1);
    we = 1'b1; wa = 5'd7; wd = 32'hA5; #1;
    $display("step write: r7=0xA5");
    chk("r7_wr_busy_a", ba[0], 1);
    chk("r7_wr_data_a", da[0], 0);
    chk("r7_wr_busy_b", bb[0], 0);
    chk("r7_wr_data_b", db[0], 32'hA5);
    @(posedge clk); #1; we = 1'b0; #1;
    chk("r7_after_busy_a", ba[0], 0);
    chk("r7_after_busy_b", bb[0], 0);
    chk("r7_after_data_a", da[0], 32'hA5);

    // ---------------- reserve + write r9 together ----------------
    we = 1'b1; wa = 5'd9; wd = 32'h99; re = 1'b1; rsa = 5'd9; ra[1] = 5'd9; #1;
    $display("step write+reserve: r9=0x99");
    chk("r9_same_data_b", db[1], 32'h99);
    chk("r9_same_busy_b", bb[1], 0);
    @(posedge clk); #1; we = 1'b0; re = 1'b0; #1;
    chk("r9_data_a", da[1], 32'h99);
    chk("r9_data_b", db[1], 32'h99);
    chk("r9_busy_a", ba[1], 1);
    chk("r9_busy_b", bb[1], 1);

    // ---------------- reset while READY ----------------
    we = 1'b1; wa = 5'd12; wd = 32'hFF;
    @(posedge clk); #1; we = 1'b0; re = 1'b1; rsa = 5'd12;
    @(posedge clk); #1; re = 1'b0; ra[0] = 5'd12; #1;
    $display("step reset-in-ready: r12=0xFF reserved");
    chk("r12_data_a", da[0], 32'hFF);
    chk("r12_busy_a", ba[0], 1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("rr_ready_a", rdy_a, 0);
    chk("rr_data_a", da[0], 0);
    chk("rr_busy_b", bb[0], 0);
    for (int i = 0; i < 31; i++) begin
      chk("rr_sweep_ready_a", rdy_a, 0);
      chk("rr_sweep_ready_b", rdy_b, 0);
      @(posedge clk); #1; #1;
    end
    chk("rr_done_a", rdy_a, 1);
    chk("rr_done_b", rdy_b, 1);
    chk("rr_r12_data_a", da[0], 0);
    chk("rr_r12_data_b", db[0], 0);
    chk("rr_r12_busy_a", ba[0], 0);
    chk("rr_r12_busy_b", bb[0], 0);
    chk("rr_r9_busy_a", ba[1], 0);

    // ---------------- 16 regs, 3 ports (dut_c) ----------------
    @(posedge clk); #1; rst_c = 1'b0; #1;
    $display("step reset: dut_c reset released");
    chk("c_rst_ready", rdy_c, 0);
    for (int i = 0; i < 15; i++) begin
      chk("c_sweep_ready", rdy_c, 0);
      @(posedge clk); #1; #1;
    end
    chk("c_sweep_done", rdy_c, 1);
    for (int p = 0; p < 3; p++) ra_c[p] = 4'd5;
    we_c = 1'b1; wa_c = 4'd5; wd_c = 32'hDEADBEEF; #1;
    $display("step write: dut_c r5=0xDEADBEEF");
    for (int p = 0; p < 3; p++) chk("c_w5_same", dc[p], 32'hDEADBEEF);
    @(posedge clk); #1; we_c = 1'b0; #1;
    for (int p = 0; p < 3; p++) chk("c_w5_next", dc[p], 32'hDEADBEEF);
    re_c = 1'b1; rsa_c = 4'd7;
    for (int p = 0; p < 3; p++) ra_c[p] = 4'd7;
    @(posedge clk); #1; re_c = 1'b0; #1;
    $display("step reserve: dut_c r7");
    for (int p = 0; p < 3; p++) chk("c_r7_busy", bc[p], 1);
    we_c = 1'b1; wa_c = 4'd12; wd_c = 32'hFF;
    @(posedge clk); #1; we_c = 1'b0; re_c = 1'b1; rsa_c = 4'd12;
    @(posedge clk); #1; re_c = 1'b0;
    for (int p = 0; p < 3; p++) ra_c[p] = 4'd12;
    #1;
    for (int p = 0; p < 3; p++) chk("c_r12_data", dc[p], 32'hFF);
    for (int p = 0; p < 3; p++) chk("c_r12_busy", bc[p], 1);
    rst_c = 1'b1;
    @(posedge clk); #1; rst_c = 1'b0; #1;
    $display("step reset-in-ready: dut_c");
    for (int i = 0; i < 15; i++) begin
      chk("c_rr_sweep_ready", rdy_c, 0);
      @(posedge clk); #1; #1;
    end
    chk("c_rr_done", rdy_c, 1);
    for (int p = 0; p < 3; p++) chk("c_rr_r12_data", dc[p], 0);
    for (int p = 0; p < 3; p++) chk("c_rr_r12_busy", bc[p], 0);
    ra_c[1] = 4'd7; #1;
    chk("c_rr_r7_busy", bc[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
